// File: rtl/spi_xfer_sequencer.sv
// APB master that drives a CORESPI slave port: control init, slave-select, per-byte TX/RX, release.
// Optional wait-state watchdog and sticky err flag when SPI_SEQ_TIMEOUT_EN is defined.
module spi_xfer_sequencer #(
    parameter logic [3:0] ADDR_CTRL   = 4'h0,
    parameter logic [3:0] ADDR_DATA   = 4'h8,
    parameter logic [3:0] ADDR_SS     = 4'hC,
    parameter logic [7:0] CTRL_INIT   = 8'h03,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_ss,
    input  logic [3:0] cmd_len,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       spi_tx_reg_empty,
    input  logic       spi_rx_data_ready,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [3:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA
);

    typedef enum logic [3:0] {
        INIT, IDLE, SS_SET, WAIT_TXE, TX_FETCH, TX_WR,
        WAIT_RXR, RX_RD, RX_PUSH, SS_CLR, FIN
    } state_t;

    state_t     state_reg, state_next;
    logic       live_reg;               // low during reset and the first cycle after it
    logic       acc_reg, acc_next;      // APB phase: 0 = SETUP, 1 = ACCESS
    logic [3:0] cnt_reg, cnt_next;
    logic [7:0] ss_reg, ss_next;
    logic [7:0] txb_reg, txb_next;
    logic [7:0] rxd_reg, rxd_next;
    logic       apb_go;
    logic       tmo_hit;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg <= INIT;
            live_reg  <= 1'b0;
            acc_reg   <= 1'b0;
            cnt_reg   <= 4'd0;
            ss_reg    <= 8'h00;
            txb_reg   <= 8'h00;
            rxd_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            live_reg  <= 1'b1;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ss_reg    <= ss_next;
            txb_reg   <= txb_next;
            rxd_reg   <= rxd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = 1'b0;
        cnt_next   = cnt_reg;
        ss_next    = ss_reg;
        txb_next   = txb_reg;
        rxd_next   = rxd_reg;
        apb_go     = 1'b0;
        cmd_ready  = 1'b0;
        tx_ready   = 1'b0;
        rx_valid   = 1'b0;
        done       = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PADDR      = 4'h0;
        PWDATA     = 8'h00;
        busy       = live_reg && (state_reg != IDLE);

        case (state_reg)
            INIT: begin
                if (live_reg) begin
                    apb_go = 1'b1;
                    PWRITE = 1'b1;
                    PADDR  = ADDR_CTRL;
                    PWDATA = CTRL_INIT;
                    if (acc_reg) state_next = IDLE;
                end
            end
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    ss_next    = cmd_ss;
                    cnt_next   = cmd_len;
                    state_next = SS_SET;
                end
            end
            SS_SET: begin
                apb_go = 1'b1;
                PWRITE = 1'b1;
                PADDR  = ADDR_SS;
                PWDATA = ss_reg;
                if (acc_reg) state_next = WAIT_TXE;
            end
            WAIT_TXE: begin
                if (spi_tx_reg_empty) state_next = TX_FETCH;
                else if (tmo_hit)     state_next = SS_CLR;
            end
            TX_FETCH: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    txb_next   = tx_data;
                    state_next = TX_WR;
                end
            end
            TX_WR: begin
                apb_go = 1'b1;
                PWRITE = 1'b1;
                PADDR  = ADDR_DATA;
                PWDATA = txb_reg;
                if (acc_reg) state_next = WAIT_RXR;
            end
            WAIT_RXR: begin
                if (spi_rx_data_ready) state_next = RX_RD;
                else if (tmo_hit)      state_next = SS_CLR;
            end
            RX_RD: begin
                apb_go = 1'b1;
                PADDR  = ADDR_DATA;
                if (acc_reg) begin
                    rxd_next   = PRDATA;
                    state_next = RX_PUSH;
                end
            end
            RX_PUSH: begin
                rx_valid = 1'b1;
                if (rx_ready) begin
                    if (cnt_reg == 4'd0) begin
                        state_next = SS_CLR;
                    end else begin
                        cnt_next   = cnt_reg - 4'd1;
                        state_next = WAIT_TXE;
                    end
                end
            end
            SS_CLR: begin
                apb_go = 1'b1;
                PWRITE = 1'b1;
                PADDR  = ADDR_SS;
                if (acc_reg) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = INIT;
        endcase

        // Every access is SETUP then ACCESS; the phase bit toggles only while an access is in progress.
        if (apb_go) begin
            PSEL     = 1'b1;
            PENABLE  = acc_reg;
            acc_next = ~acc_reg;
        end
    end

    assign rx_data = rxd_reg;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_reg;
    logic             err_reg;
    logic             in_wait;
    logic             pace_ok;

    assign in_wait = (state_reg == WAIT_TXE) || (state_reg == WAIT_RXR);
    assign pace_ok = (state_reg == WAIT_TXE) ? spi_tx_reg_empty : spi_rx_data_ready;
    assign tmo_hit = in_wait && !pace_ok && (tmo_reg == TMO_W'(TIMEOUT_CYC - 1));

    // Counter is zero outside the wait states, so each entry starts a fresh window.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (in_wait && !pace_ok && !tmo_hit) tmo_reg <= tmo_reg + 1'b1;
            else                                 tmo_reg <= '0;
            if (state_reg == IDLE && cmd_valid)  err_reg <= 1'b0;
            else if (tmo_hit)                    err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic [31:0] tmo_cfg_unused;
    assign tmo_cfg_unused = 32'(TIMEOUT_CYC);
    assign tmo_hit        = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: APB sequence, RX stream, backpressure, reset, watchdog.
module tb_spi_xfer_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_ss = 8'h00;
    logic [3:0] cmd_len = 4'd0;
    logic       tx_valid = 1'b1;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       busy, done, err;
    logic       spi_tx_reg_empty = 1'b1;
    logic       spi_rx_data_ready = 1'b1;
    logic       PSEL, PENABLE, PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
    } acc_t;

    acc_t       log_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_bytes [0:15];
    int         tx_cnt = 0, tx_base = 0;
    logic       echo = 1'b0;
    logic [7:0] prd_const = 8'h3C;
    logic [7:0] last_tx = 8'h00;
    int         cyc = 0, hs_cyc = 0, done_cyc = 0, done_n = 0, tx_acc_cyc = 0, err_cyc = 0;
    int         apb_bad = 0;
    logic       p_psel = 1'b0, p_pen = 1'b0, p_wr = 1'b0, p_err = 1'b0;
    logic [3:0] p_addr = 4'h0;
    logic [7:0] p_wd = 8'h00;
    int         errors = 0, checks = 0;

    assign tx_data = tx_bytes[4'(tx_cnt - tx_base)];
    assign PRDATA  = echo ? last_tx : prd_const;

    spi_xfer_sequencer #(.TIMEOUT_CYC(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ss(cmd_ss), .cmd_len(cmd_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .busy(busy), .done(done), .err(err),
        .spi_tx_reg_empty(spi_tx_reg_empty), .spi_rx_data_ready(spi_rx_data_ready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA)
    );

    // Bus monitor: logs completed accesses, handshakes and APB protocol violations.
    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (PSEL && PENABLE) begin
            log_q.push_back({PWRITE, PADDR, PWRITE ? PWDATA : PRDATA});
            if (!p_psel || p_pen || PADDR != p_addr || PWRITE != p_wr || (PWRITE && PWDATA != p_wd))
                apb_bad <= apb_bad + 1;
        end
        if ((PSEL && !PENABLE && p_psel) || (PENABLE && !PSEL))
            apb_bad <= apb_bad + 1;
        if (PSEL && PENABLE && PWRITE && PADDR == 4'h8) begin
            last_tx    <= PWDATA;
            tx_acc_cyc <= cyc;
        end
        p_psel <= PSEL; p_pen <= PENABLE; p_wr <= PWRITE; p_addr <= PADDR; p_wd <= PWDATA;
        if (cmd_valid && cmd_ready) hs_cyc <= cyc;
        if (done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (rx_valid && rx_ready) rx_q.push_back(rx_data);
        if (tx_valid && tx_ready) tx_cnt <= tx_cnt + 1;
        if (err && !p_err) err_cyc <= cyc;
        p_err <= err;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_done(input int d0, input int lim, output bit ok);
        for (int i = 0; i < lim && done_n == d0; i++) tick();
        ok = (done_n != d0);
    endtask

    task automatic test_reset();
        bit seen;
        tick(); tick();
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++; $display("FAIL reset_apb: PSEL=%b PENABLE=%b, required 0 0", PSEL, PENABLE); end
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctl: cmd_ready=%b busy=%b done=%b, required 0 0 0", cmd_ready, busy, done); end
        checks++; if (rx_data !== 8'h00 || err !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL reset_data: rx_data=%h err=%b rx_valid=%b tx_ready=%b, required 00 0 0 0", rx_data, err, rx_valid, tx_ready); end
        log_q.delete();
        PRESET = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: busy=%b, required 1", busy); end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = cmd_ready;
        end
        checks++; if (!seen) begin errors++; $display("FAIL init_ready: cmd_ready never rose within 12 cycles"); end
        checks++; if (log_q.size() != 1 || log_q[0] !== {1'b1, 4'h0, 8'h03}) begin errors++; $display("FAIL init_write: %0d accesses, first=%h, required 1 access W 0/03", log_q.size(), log_q[0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: busy=%b, required 0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        int d0;
        tx_base = tx_cnt; tx_bytes[0] = 8'hA5;
        echo = 1'b0; prd_const = 8'h3C;
        log_q.delete(); rx_q.delete();
        d0 = done_n;
        cmd_ss = 8'h04; cmd_len = 4'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_accept: cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy); end
        wait_done(d0, 100, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL single_done: no done within 100 cycles"); end
        checks++; if (done_n != d0 + 1) begin errors++; $display("FAIL single_pulse: done high %0d cycles, required 1", done_n - d0); end
        checks++; if (done_cyc - hs_cyc != 13) begin errors++; $display("FAIL single_latency: %0d cycles, required 13", done_cyc - hs_cyc); end
        checks++; if (log_q.size() != 4) begin errors++; $display("FAIL single_count: %0d accesses, required 4", log_q.size()); end
        checks++; if (log_q[0] !== {1'b1, 4'hC, 8'h04}) begin errors++; $display("FAIL single_ss: got %h, required %h", log_q[0], {1'b1, 4'hC, 8'h04}); end
        checks++; if (log_q[1] !== {1'b1, 4'h8, 8'hA5}) begin errors++; $display("FAIL single_tx: got %h, required %h", log_q[1], {1'b1, 4'h8, 8'hA5}); end
        checks++; if (log_q[2] !== {1'b0, 4'h8, 8'h3C}) begin errors++; $display("FAIL single_rd: got %h, required %h", log_q[2], {1'b0, 4'h8, 8'h3C}); end
        checks++; if (log_q[3] !== {1'b1, 4'hC, 8'h00}) begin errors++; $display("FAIL single_ssclr: got %h, required %h", log_q[3], {1'b1, 4'hC, 8'h00}); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C || rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx: beats=%0d first=%h rx_data=%h, required 1 3C 3C", rx_q.size(), rx_q[0], rx_data); end
        checks++; if (apb_bad != 0 || err !== 1'b0) begin errors++; $display("FAIL single_proto: apb violations=%0d err=%b, required 0 0", apb_bad, err); end
    endtask

    task automatic test_multi();
        bit ok;
        int d0, nclr;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        tx_base = tx_cnt;
        for (int k = 0; k < 4; k++) tx_bytes[k] = exp_b[k];
        echo = 1'b1;
        log_q.delete(); rx_q.delete();
        d0 = done_n;
        cmd_ss = 8'h81; cmd_len = 4'd3; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_done(d0, 200, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL multi_done: no done within 200 cycles"); end
        checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL multi_beats: %0d rx beats, required 4", rx_q.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rx_q[k] !== exp_b[k]) begin errors++; $display("FAIL multi_rx%0d: got %h, required %h", k, rx_q[k], exp_b[k]); end
            checks++; if (log_q[1 + 2 * k] !== {1'b1, 4'h8, exp_b[k]} || log_q[2 + 2 * k] !== {1'b0, 4'h8, exp_b[k]}) begin errors++; $display("FAIL multi_order%0d: got %h %h, required W8/%h then R8/%h", k, log_q[1 + 2 * k], log_q[2 + 2 * k], exp_b[k], exp_b[k]); end
        end
        nclr = 0;
        foreach (log_q[i]) if (log_q[i] === {1'b1, 4'hC, 8'h00}) nclr++;
        checks++; if (log_q.size() != 10 || nclr != 1) begin errors++; $display("FAIL multi_ss: %0d accesses with %0d SS clears, required 10 and 1", log_q.size(), nclr); end
        checks++; if (log_q[0] !== {1'b1, 4'hC, 8'h81} || log_q[9] !== {1'b1, 4'hC, 8'h00}) begin errors++; $display("FAIL multi_frame: first=%h last=%h, required %h %h", log_q[0], log_q[9], {1'b1, 4'hC, 8'h81}, {1'b1, 4'hC, 8'h00}); end
    endtask

    task automatic test_backpressure();
        bit ok, seen;
        int d0, n0;
        tx_base = tx_cnt; tx_bytes[0] = 8'h5A; tx_bytes[1] = 8'h6B;
        echo = 1'b1; rx_ready = 1'b0;
        log_q.delete(); rx_q.delete();
        d0 = done_n;
        cmd_ss = 8'h02; cmd_len = 4'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = rx_valid;
        end
        checks++; if (!seen || rx_data !== 8'h5A) begin errors++; $display("FAIL bp_first: rx_valid=%b rx_data=%h, required 1 5A", rx_valid, rx_data); end
        n0 = log_q.size();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (PSEL !== 1'b0) begin errors++; $display("FAIL bp_idle%0d: PSEL=%b, required 0", i, PSEL); end
            checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A || busy !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: rx_valid=%b rx_data=%h busy=%b, required 1 5A 1", i, rx_valid, rx_data, busy); end
        end
        checks++; if (log_q.size() != n0 || n0 != 3) begin errors++; $display("FAIL bp_frozen: %0d then %0d accesses, required 3 and 3", n0, log_q.size()); end
        rx_ready = 1'b1;
        wait_done(d0, 100, ok);
        tick();
        checks++; if (!ok || rx_q.size() != 2 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'h6B) begin errors++; $display("FAIL bp_resume: done=%b beats=%0d %h %h, required 1 2 5A 6B", ok, rx_q.size(), rx_q[0], rx_q[1]); end
        checks++; if (log_q.size() != 6 || apb_bad != 0) begin errors++; $display("FAIL bp_count: %0d accesses, %0d violations, required 6 and 0", log_q.size(), apb_bad); end
    endtask

    task automatic test_timeout();
        bit ok;
        int d0, t0;
        tx_base = tx_cnt; tx_bytes[0] = 8'h91; tx_bytes[1] = 8'h92; tx_bytes[2] = 8'h93;
        echo = 1'b1; spi_rx_data_ready = 1'b0;
        log_q.delete(); rx_q.delete();
        d0 = done_n; t0 = tx_cnt;
        cmd_ss = 8'h10; cmd_len = 4'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
        for (int i = 0; i < 100 && err !== 1'b1; i++) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: err=%b, required 1", err); end
        checks++; if (err_cyc - tx_acc_cyc != 17) begin errors++; $display("FAIL tmo_time: err rose %0d cycles after TX write, required 17", err_cyc - tx_acc_cyc); end
        wait_done(d0, 20, ok);
        tick();
        checks++; if (!ok || done_n != d0 + 1) begin errors++; $display("FAIL tmo_done: done pulses=%0d, required 1", done_n - d0); end
        checks++; if (log_q.size() != 3 || log_q[1] !== {1'b1, 4'h8, 8'h91} || log_q[2] !== {1'b1, 4'hC, 8'h00}) begin errors++; $display("FAIL tmo_seq: %0d accesses, %h %h, required 3 W8/91 WC/00", log_q.size(), log_q[1], log_q[2]); end
        checks++; if (rx_q.size() != 0 || tx_cnt - t0 != 1) begin errors++; $display("FAIL tmo_abandon: rx beats=%0d tx taken=%0d, required 0 and 1", rx_q.size(), tx_cnt - t0); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: err=%b, required 1", err); end
        spi_rx_data_ready = 1'b1;
        tx_base = tx_cnt;
        d0 = done_n; cmd_len = 4'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_clear: err=%b, required 0", err); end
        wait_done(d0, 100, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL tmo_next: no done within 100 cycles"); end
`else
        for (int i = 0; i < 40; i++) tick();
        checks++; if (err !== 1'b0 || done_n != d0 || PSEL !== 1'b0) begin errors++; $display("FAIL wait_block: err=%b done pulses=%0d PSEL=%b, required 0 0 0", err, done_n - d0, PSEL); end
        spi_rx_data_ready = 1'b1;
        wait_done(d0, 200, ok);
        tick();
        checks++; if (!ok || rx_q.size() != 3 || rx_q[2] !== 8'h93) begin errors++; $display("FAIL wait_resume: done=%b beats=%0d last=%h, required 1 3 93", ok, rx_q.size(), rx_q[2]); end
        checks++; if (tx_cnt - t0 != 3 || err !== 1'b0) begin errors++; $display("FAIL wait_tx: tx taken=%0d err=%b, required 3 0", tx_cnt - t0, err); end
`endif
    endtask

    task automatic test_reset_mid();
        bit seen;
        tx_base = tx_cnt; tx_bytes[0] = 8'h77;
        echo = 1'b0;
        cmd_ss = 8'h01; cmd_len = 4'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = PSEL && PENABLE && PWRITE && (PADDR == 4'h8);
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_reach: TX_WR ACCESS not seen within 20 cycles"); end
        PRESET = 1'b1;
        #1;
        checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin errors++; $display("FAIL mid_drop: PSEL=%b PENABLE=%b, required 0 0", PSEL, PENABLE); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL mid_clear: busy=%b cmd_ready=%b rx_data=%h, required 0 0 00", busy, cmd_ready, rx_data); end
        log_q.delete();
        tick(); tick();
        PRESET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            seen = cmd_ready;
        end
        checks++; if (!seen || log_q.size() != 1 || log_q[0] !== {1'b1, 4'h0, 8'h03}) begin errors++; $display("FAIL mid_reinit: ready=%b %0d accesses first=%h, required 1 1 %h", seen, log_q.size(), log_q[0], {1'b1, 4'h0, 8'h03}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
